// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending (scoreboard) bits and a self-clearing reset sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   output logic                     ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clrCnt;
   logic [DATA_W-1:0]   r_regs [DEPTH];
   logic [DEPTH-1:0]    r_pending;

   logic w_wrOk;
   logic w_rsvOk;

   assign ready   = (r_state == RUN);
   assign w_wrOk  = ready && wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
   assign w_rsvOk = ready && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Reset leaves the array alone; the CLEAR sweep zeroes one entry per edge instead.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= CLEAR;
         r_clrCnt  <= '0;
         r_pending <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_regs[r_clrCnt] <= '0;
               r_clrCnt         <= r_clrCnt + ADDR_W'(1);
               if (r_clrCnt == '1) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_wrOk) begin
                  r_regs[wr_addr]    <= wr_data;
                  r_pending[wr_addr] <= 1'b0;
               end
               // Reservation comes last so it wins over a same-edge write-back.
               if (w_rsvOk) begin
                  r_pending[rsv_addr] <= 1'b1;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_isZero;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;

      assign w_addr   = rd_addr[p*ADDR_W +: ADDR_W];
      assign w_isZero = (ZERO_REG != 0) && (w_addr == '0);

      always_comb begin
         w_data = r_regs[w_addr];
         w_busy = r_pending[w_addr];
`ifdef REGFILE_BYPASS_EN
         if (w_wrOk && (w_addr == wr_addr)) begin
            w_data = wr_data;
            w_busy = w_rsvOk && (rsv_addr == wr_addr);
         end
`else
`endif
         if (!ready || w_isZero) begin
            w_data = '0;
            w_busy = 1'b0;
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = w_data;
      assign rd_busy[p]                  = w_busy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: clear sweep, read/write, register 0, scoreboard, bypass and mid-run reset.
// Expectations follow REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_sb;

   logic        clock;
   logic        reset_n;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;

   int nChecks = 0;
   int nPass   = 0;

   regfile_sb #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just past it.
   task automatic stepClock(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] ra);
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rsv_en   = re;
      rsv_addr = ra;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Count edges after reset release: ready low through edge 31, high after edge 32.
   task automatic checkClearSweep(input string tag);
      for (int i = 1; i <= 32; i++) begin
         stepClock(1);
         checkOutput(tag, {63'd0, ready}, (i == 32) ? 64'd1 : 64'd0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      rd_addr = '0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      stepClock(2);
      checkOutput("reset_ready", {63'd0, ready}, 64'd0);
      checkOutput("reset_data",  rd_data, 64'd0);
      checkOutput("reset_busy",  {62'd0, rd_busy}, 64'd0);

      reset_n = 1'b1;
      checkClearSweep("clear_ready");

      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(a), 5'(31 - a)};
         #1;
         checkOutput("clear_data", rd_data, 64'd0);
         checkOutput("clear_busy", {62'd0, rd_busy}, 64'd0);
      end

      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      rd_addr = {5'd5, 5'd5};
      #1;
      checkOutput("wr_r5_both", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
      checkOutput("wr_r5_busy", {62'd0, rd_busy}, 64'd0);

      applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      rd_addr = {5'd0, 5'd0};
      #1;
      checkOutput("r0_data", rd_data, 64'd0);
      checkOutput("r0_busy", {62'd0, rd_busy}, 64'd0);

      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      rd_addr = {5'd5, 5'd7};
      #1;
      checkOutput("rsv_r7_busy", {62'd0, rd_busy}, 64'b01);

      applyStimulus(1'b1, 5'd7, 32'h55, 1'b1, 5'd7);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      checkOutput("wr_rsv_r7_busy", {62'd0, rd_busy}, 64'b01);
      checkOutput("wr_rsv_r7_data", rd_data, {32'hDEADBEEF, 32'h55});

      applyStimulus(1'b1, 5'd7, 32'h66, 1'b0, 5'd0);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      checkOutput("wr_r7_busy", {62'd0, rd_busy}, 64'd0);
      checkOutput("wr_r7_data", rd_data, {32'hDEADBEEF, 32'h66});

      // r3 holds 0x11 and is pending before the bypass probe.
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      stepClock(1);
      applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0);
      rd_addr = {5'd3, 5'd7};
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("byp_data", rd_data, {32'hA5A5A5A5, 32'h66});
      checkOutput("byp_busy", {62'd0, rd_busy}, 64'b00);
`else
      checkOutput("byp_data", rd_data, {32'h11, 32'h66});
      checkOutput("byp_busy", {62'd0, rd_busy}, 64'b10);
`endif
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      checkOutput("post_byp_data", rd_data, {32'hA5A5A5A5, 32'h66});
      checkOutput("post_byp_busy", {62'd0, rd_busy}, 64'd0);

      reset_n = 1'b0;
      stepClock(1);
      checkOutput("rst_run_ready", {63'd0, ready}, 64'd0);
      reset_n = 1'b1;
      stepClock(10);
      checkOutput("mid_clear_ready", {63'd0, ready}, 64'd0);
      reset_n = 1'b0;
      stepClock(1);
      reset_n = 1'b1;
      checkClearSweep("reclear_ready");

      rd_addr = {5'd3, 5'd9};
      reset_n = 1'b0;
      applyStimulus(1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd3);
      stepClock(1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checkOutput("rst_wr_ready", {63'd0, ready}, 64'd0);
      checkOutput("rst_wr_data",  rd_data, 64'd0);
      reset_n = 1'b1;
      checkClearSweep("rerun_ready");
      #1;
      checkOutput("rst_wr_r9_data", rd_data, 64'd0);
      checkOutput("rst_wr_busy",    {62'd0, rd_busy}, 64'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
